// File: rtl/uart_tx_fifo_if.sv
// Byte-write / serial-status bundle between control logic and the buffered UART transmitter.
// master = control side (writes bytes, selects baud), slave = transmitter.
// fifo_cnt is FIFO_AW+1 bits wide so it can hold the full-depth count.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic [2:0]       tx_baud;
  logic [7:0]       tx_dat;
  logic             tx_en;
  logic             tx_full;
  logic [FIFO_AW:0] fifo_cnt;
  logic             tx_ovf;
  logic             tx;
  logic             tx_ing;
  logic             tx_ok;

  modport master (
    output tx_baud, tx_dat, tx_en,
    input  tx_full, fifo_cnt, tx_ovf, tx, tx_ing, tx_ok
  );

  modport slave (
    input  tx_baud, tx_dat, tx_en,
    output tx_full, fifo_cnt, tx_ovf, tx, tx_ing, tx_ok
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 2**FIFO_AW byte FIFO feeding an 8N1 (8E1 with UART_PARITY_EN) serialiser.
// Latency: write at edge N into an idle, empty block -> start bit on tx from edge N+2; frames back-to-back.
// Backpressure: tx_full (registered count) gates writes; writes while full are dropped and set sticky tx_ovf.
module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_fifo_if.slave     i_bus
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_MAX = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Clocks per bit for each baud select code (25 MHz core clock).
  function automatic logic [13:0] baud_div(input logic [2:0] sel);
    logic [13:0] d;
    case (sel)
      3'd1:    d = 14'd10416;
      3'd2:    d = 14'd5208;
      3'd3:    d = 14'd2604;
      3'd4:    d = 14'd1302;
      3'd5:    d = 14'd651;
      3'd6:    d = 14'd434;
      3'd7:    d = 14'd217;
      default: d = 14'd2604;
    endcase
    return d;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_ovf;

  // Serialiser state
  state_t             r_state;
  state_t             w_nxt_state;
  logic [13:0]        r_timer;
  logic [13:0]        r_div;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
`ifdef UART_PARITY_EN
  logic               r_par;
`endif

  // Line-side output registers
  logic               r_tx;
  logic               r_tx_ing;
  logic               r_ok_d;
  logic               r_tx_ok;

  // Combinational control
  logic               w_full;
  logic               w_wr;
  logic               w_pop;
  logic               w_not_empty;
  logic               w_last;
  logic [7:0]         w_head;
  logic               w_tx_nxt;
  logic               w_ing_nxt;
  logic               w_ok_nxt;

  // Full is derived from the registered count, so a pop in the same cycle cannot admit a write.
  assign w_full      = (r_cnt == CNT_MAX);
  assign w_wr        = i_bus.tx_en & ~w_full;
  assign w_not_empty = (r_cnt != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_last      = (r_timer == (r_div - 14'd1));

  // Byte storage: written on accepted strobes only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_bus.tx_dat;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      if (i_bus.tx_en && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // FSM next state, pop request and next line values (the line lags the state by one register).
  always_comb begin
    w_nxt_state = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    w_ing_nxt   = 1'b0;
    w_ok_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_nxt_state = S_START;
        end
      end
      S_START: begin
        w_tx_nxt  = 1'b0;
        w_ing_nxt = 1'b1;
        if (w_last) begin
          w_nxt_state = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_nxt  = r_shift[0];
        w_ing_nxt = 1'b1;
        if (w_last && (r_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
          w_nxt_state = S_PARITY;
`else
          w_nxt_state = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        w_tx_nxt  = r_par;
        w_ing_nxt = 1'b1;
        if (w_last) begin
          w_nxt_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt  = 1'b1;
        w_ing_nxt = 1'b1;
        if (w_last) begin
          w_ok_nxt = 1'b1;
          if (w_not_empty) begin
            // Chain straight into the next start bit: no idle gap between frames.
            w_pop       = 1'b1;
            w_nxt_state = S_START;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Bit timer, bit index, shift register and per-frame divisor latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= '0;
      r_div   <= 14'd2604;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_pop) begin
      // Baud select is only looked at here, so a mid-frame change waits for the next frame.
      r_shift <= w_head;
      r_div   <= baud_div(i_bus.tx_baud);
      r_timer <= '0;
      r_bit   <= '0;
`ifdef UART_PARITY_EN
      r_par   <= ^w_head;
`endif
    end else if (r_state != S_IDLE) begin
      if (w_last) begin
        r_timer <= '0;
        if (r_state == S_DATA) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
      end else begin
        r_timer <= r_timer + 14'd1;
      end
    end
  end

  // Registered line outputs; tx_ok gets one extra stage so it lands on the edge closing the stop bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx     <= 1'b1;
      r_tx_ing <= 1'b0;
      r_ok_d   <= 1'b0;
      r_tx_ok  <= 1'b0;
    end else begin
      r_tx     <= w_tx_nxt;
      r_tx_ing <= w_ing_nxt;
      r_ok_d   <= w_ok_nxt;
      r_tx_ok  <= r_ok_d;
    end
  end

  assign i_bus.tx_full  = w_full;
  assign i_bus.fifo_cnt = r_cnt;
  assign i_bus.tx_ovf   = r_ovf;
  assign i_bus.tx       = r_tx;
  assign i_bus.tx_ing   = r_tx_ing;
  assign i_bus.tx_ok    = r_tx_ok;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: writes bytes, decodes the serial line cycle by cycle against a scoreboard.
// Each expected frame (byte + divisor) is queued on write and consumed when a start bit appears.
// Honours UART_PARITY_EN (8E1 frame) when the design is built with it.
module tb_uart_tx_fifo;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] d;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   wr_cyc = 0;

  exp_t sb_q[$];
  int   starts[$];
  int   ok_cyc[$];

  int   m_k = -1;
  int   m_frame = 0;
  exp_t m_e;
  logic m_ok = 1'b1;

  uart_tx_fifo_if #(.FIFO_AW(4)) bus ();

  uart_tx_fifo #(.FIFO_AW(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Line monitor: samples 2 time units after each rising edge.
  always begin
    logic ended;
    int   idx;
    @(posedge clk);
    #2;
    ended = 1'b0;
    if (rst) begin
      m_k = -1;
    end else begin
      if (m_k >= 0) begin
        if (m_k == NB * m_e.div) begin
          chk($sformatf("f%0d_tx_ok", m_frame), 32'(bus.tx_ok), 32'd1);
          ok_cyc.push_back(cyc);
          m_k   = -1;
          ended = 1'b1;
        end else begin
          idx = m_k / m_e.div;
          if (bus.tx !== frame_bit(m_e.d, idx) || bus.tx_ing !== 1'b1 || bus.tx_ok !== 1'b0)
            m_ok = 1'b0;
          if ((m_k % m_e.div) == (m_e.div - 1)) begin
            chk($sformatf("f%0d_d%0h_bit%0d_line", m_frame, m_e.d, idx), 32'(m_ok), 32'd1);
            m_ok = 1'b1;
          end
          m_k++;
        end
      end
      if (m_k < 0) begin
        if (!ended && bus.tx_ok === 1'b1)
          chk("spurious_tx_ok", 32'(bus.tx_ok), 32'd0);
        if (bus.tx === 1'b0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 32'(sb_q.size()), 32'd1);
          end else begin
            m_e = sb_q.pop_front();
            m_frame++;
            starts.push_back(cyc);
            m_ok = 1'b1;
            if (bus.tx_ing !== 1'b1) m_ok = 1'b0;
            m_k = 1;
            if (m_e.div == 1) begin
              chk("bad_div", 32'(m_e.div), 32'd2);
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input int div, input bit accept);
    @(negedge clk);
    bus.tx_dat = d;
    bus.tx_en  = 1'b1;
    if (accept) sb_q.push_back('{d: d, div: div});
    @(negedge clk);
    bus.tx_en = 1'b0;
    wr_cyc    = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(sb_q.size() == 0 && m_k < 0 && bus.tx_ing == 1'b0 && bus.fifo_cnt == '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_starts(input int cnt, input int budget);
    int n = 0;
    while (starts.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (starts.size() < cnt) chk("start_timeout", 32'(starts.size()), 32'(cnt));
  endtask

  initial begin
    bus.tx_baud = 3'd0;
    bus.tx_dat  = 8'h00;
    bus.tx_en   = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_tx",       32'(bus.tx),       32'd1);
    chk("rst_tx_ing",   32'(bus.tx_ing),   32'd0);
    chk("rst_tx_ok",    32'(bus.tx_ok),    32'd0);
    chk("rst_tx_full",  32'(bus.tx_full),  32'd0);
    chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("rst_tx_ovf",   32'(bus.tx_ovf),   32'd0);

    // Single byte, first-start latency and tx_ok timing
    bus.tx_baud = 3'd7;
    starts.delete(); ok_cyc.delete();
    wr(8'h55, 217, 1'b1);
    wait_starts(1, 20);
    if (starts.size() > 0) chk("latency", 32'(starts[0] - wr_cyc), 32'd2);
    wait_idle(4000);
    if (ok_cyc.size() > 0 && starts.size() > 0)
      chk("ok_after_fall", 32'(ok_cyc[0] - starts[0]), 32'(NB * 217));
    else
      chk("ok_seen", 32'(ok_cyc.size()), 32'd1);

    // Two bytes back to back: second start right after first stop
    starts.delete(); ok_cyc.delete();
    wr(8'hA3, 217, 1'b1);
    wr(8'h0F, 217, 1'b1);
    wait_idle(8000);
    chk("b2b_frames", 32'(starts.size()), 32'd2);
    chk("b2b_oks",    32'(ok_cyc.size()), 32'd2);
    if (starts.size() == 2) chk("b2b_start_gap", 32'(starts[1] - starts[0]), 32'(NB * 217));
    if (ok_cyc.size() == 2) chk("b2b_ok_gap",    32'(ok_cyc[1] - ok_cyc[0]), 32'(NB * 217));

    // Fill while the line is busy: 16 queued, 17th dropped
    wr(8'h10, 217, 1'b1);
    @(negedge clk);
    chk("fill_inflight_cnt", 32'(bus.fifo_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'h20 + i), 217, i < 16);
      if (i == 15) begin
        chk("fill_full_at16", 32'(bus.tx_full), 32'd1);
        chk("fill_no_ovf_16", 32'(bus.tx_ovf),  32'd0);
      end
    end
    chk("fill_cnt",  32'(bus.fifo_cnt), 32'd16);
    chk("fill_full", 32'(bus.tx_full),  32'd1);
    chk("fill_ovf",  32'(bus.tx_ovf),   32'd1);
    wait_idle(45000);
    chk("drain_cnt",  32'(bus.fifo_cnt), 32'd0);
    chk("drain_full", 32'(bus.tx_full),  32'd0);
    chk("ovf_sticky", 32'(bus.tx_ovf),   32'd1);

    // Baud change mid-frame only affects the next frame
    starts.delete();
    wr(8'h3C, 217,  1'b1);
    wr(8'hC3, 2604, 1'b1);
    repeat (300) @(negedge clk);
    bus.tx_baud = 3'd0;
    wait_idle(32000);
    if (starts.size() == 2) chk("baud_f1_len", 32'(starts[1] - starts[0]), 32'(NB * 217));
    else chk("baud_frames", 32'(starts.size()), 32'd2);

    // Reset mid-DATA aborts the frame and empties the FIFO
    bus.tx_baud = 3'd7;
    wr(8'hC6, 217, 1'b1);
    wr(8'h5A, 217, 1'b1);
    repeat (700) @(negedge clk);
    chk("pre_rst_cnt", 32'(bus.fifo_cnt), 32'd1);
    chk("pre_rst_ing", 32'(bus.tx_ing),   32'd1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx",     32'(bus.tx),       32'd1);
    chk("midrst_ing",    32'(bus.tx_ing),   32'd0);
    chk("midrst_cnt",    32'(bus.fifo_cnt), 32'd0);
    chk("midrst_ok",     32'(bus.tx_ok),    32'd0);
    chk("midrst_ovf",    32'(bus.tx_ovf),   32'd0);
    repeat (2500) @(negedge clk);
    chk("post_rst_tx",   32'(bus.tx),       32'd1);
    chk("post_rst_ing",  32'(bus.tx_ing),   32'd0);

    // 0x07: three ones, so the even-parity bit (when enabled) is 1
    starts.delete(); ok_cyc.delete();
    wr(8'h07, 217, 1'b1);
    wait_idle(4000);
    if (ok_cyc.size() == 1 && starts.size() == 1)
      chk("f07_frame_len", 32'(ok_cyc[0] - starts[0]), 32'(NB * 217));
    else
      chk("f07_seen", 32'(ok_cyc.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
